// File: rtl/rca_pkg.sv
// ============================================================================
// Module      : rca_pkg
// Description : Shared constants for the 4-bit ripple-carry adder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rca_pkg;

  localparam int RCA_WIDTH = 4;

  // Reset contents of the registered result stage.
  localparam logic [RCA_WIDTH-1:0] RCA_SUM_RST  = '0;
  localparam logic                 RCA_FLAG_RST = 1'b0;

endpackage : rca_pkg

`default_nettype wire

// File: rtl/rca_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : Single-bit full-adder cell used as one ripple stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

`default_nettype wire

// File: rtl/rca.sv
// ============================================================================
// Module      : rca
// Description : 4-bit ripple-carry adder with combinational sum/carry and a
//               registered sum, carry-out and two's-complement overflow.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rca
  import rca_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a0,
  input  logic                 a1,
  input  logic                 a2,
  input  logic                 a3,
  input  logic                 b0,
  input  logic                 b1,
  input  logic                 b2,
  input  logic                 b3,
  input  logic                 cin,
  output logic                 s0,
  output logic                 s1,
  output logic                 s2,
  output logic                 s3,
  output logic                 c3,
  output logic [RCA_WIDTH-1:0] sum_q,
  output logic                 cout_q,
  output logic                 ovf_q
);

  logic [RCA_WIDTH-1:0] w_a;
  logic [RCA_WIDTH-1:0] w_b;
  logic [RCA_WIDTH-1:0] w_s;
  // w_c[i] is the carry into stage i; w_c[RCA_WIDTH] is the final carry out.
  logic [RCA_WIDTH:0]   w_c;
  logic                 w_ovf;

  logic [RCA_WIDTH-1:0] r_sum_q;
  logic                 r_cout_q;
  logic                 r_ovf_q;

  assign w_a    = {a3, a2, a1, a0};
  assign w_b    = {b3, b2, b1, b0};
  assign w_c[0] = cin;

  for (genvar i = 0; i < RCA_WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (w_a[i]),
      .b    (w_b[i]),
      .cin  (w_c[i]),
      .s    (w_s[i]),
      .cout (w_c[i+1])
    );
  end

  assign s0 = w_s[0];
  assign s1 = w_s[1];
  assign s2 = w_s[2];
  assign s3 = w_s[3];
  assign c3 = w_c[RCA_WIDTH];

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign w_ovf = w_c[RCA_WIDTH-1] ^ w_c[RCA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_q  <= RCA_SUM_RST;
      r_cout_q <= RCA_FLAG_RST;
      r_ovf_q  <= RCA_FLAG_RST;
    end else begin
      r_sum_q  <= w_s;
      r_cout_q <= w_c[RCA_WIDTH];
      r_ovf_q  <= w_ovf;
    end
  end

  assign sum_q  = r_sum_q;
  assign cout_q = r_cout_q;
  assign ovf_q  = r_ovf_q;

endmodule : rca

`default_nettype wire

// File: tb/tb_rca.sv
// ============================================================================
// Module      : tb_rca
// Description : Self-checking bench for the 4-bit ripple-carry adder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rca;

  logic       clk;
  logic       rst;
  logic       a0, a1, a2, a3;
  logic       b0, b1, b2, b3;
  logic       cin;
  logic       s0, s1, s2, s3;
  logic       c3;
  logic [3:0] sum_q;
  logic       cout_q;
  logic       ovf_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry: {cout, ovf, sum[3:0]} expected at the next register update.
  logic [5:0] sb_q[$];

  rca dut (
    .clk    (clk),
    .rst    (rst),
    .a0     (a0),
    .a1     (a1),
    .a2     (a2),
    .a3     (a3),
    .b0     (b0),
    .b1     (b1),
    .b2     (b2),
    .b3     (b3),
    .cin    (cin),
    .s0     (s0),
    .s1     (s1),
    .s2     (s2),
    .s3     (s3),
    .c3     (c3),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
    {a3, a2, a1, a0} = a;
    {b3, b2, b1, b0} = b;
    cin = ci;
  endtask

  // Drive one operand set at the falling edge, check the combinational result,
  // queue the registered expectation and compare it after the next rising edge.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic [3:0] exp_s, input logic exp_c, input logic exp_ovf,
                       input string tag);
    logic [5:0] e;
    @(negedge clk);
    drive(a, b, ci);
    #1;
    chk({tag, ".s"},  {4'h0, s3, s2, s1, s0}, {4'h0, exp_s});
    chk({tag, ".c3"}, {7'h0, c3},             {7'h0, exp_c});
    sb_q.push_back({exp_c, exp_ovf, exp_s});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 8'h01, 8'h00);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".sum_q"},  {4'h0, sum_q},  {4'h0, e[3:0]});
      chk({tag, ".cout_q"}, {7'h0, cout_q}, {7'h0, e[5]});
      chk({tag, ".ovf_q"},  {7'h0, ovf_q},  {7'h0, e[4]});
    end
  endtask

  initial begin
    logic [4:0] full;
    logic       m_ovf;

    rst = 1'b0;
    drive(4'h0, 4'h0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("reset.sum_q",  {4'h0, sum_q},  8'h00);
    chk("reset.cout_q", {7'h0, cout_q}, 8'h00);
    chk("reset.ovf_q",  {7'h0, ovf_q},  8'h00);
    @(negedge clk);
    rst = 1'b0;

    apply(4'd1,  4'd12, 1'b0, 4'b1101, 1'b0, 1'b0, "d1_12_0");
    apply(4'd5,  4'd10, 1'b1, 4'b0000, 1'b1, 1'b0, "d5_10_1");
    apply(4'd6,  4'd5,  1'b0, 4'b1011, 1'b0, 1'b1, "d6_5_0");
    apply(4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0, "d15_15_1");
    apply(4'd8,  4'd8,  1'b0, 4'b0000, 1'b1, 1'b1, "d8_8_0");
    apply(4'd15, 4'd0,  1'b1, 4'b0000, 1'b1, 1'b0, "d15_0_1");

    // Inputs changing between edges must not disturb the registers.
    @(negedge clk);
    drive(4'd3, 4'd3, 1'b0);
    #1;
    chk("hold.sum_q",  {4'h0, sum_q},  8'h00);
    chk("hold.cout_q", {7'h0, cout_q}, 8'h01);

    // Mid-operation asynchronous reset.
    apply(4'd6, 4'd5, 1'b0, 4'b1011, 1'b0, 1'b1, "pre_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.sum_q",  {4'h0, sum_q},  8'h00);
    chk("rst_mid.cout_q", {7'h0, cout_q}, 8'h00);
    chk("rst_mid.ovf_q",  {7'h0, ovf_q},  8'h00);
    chk("rst_mid.s",      {4'h0, s3, s2, s1, s0}, 8'h0B);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rel.sum_q", {4'h0, sum_q}, 8'h0B);
    chk("rst_rel.ovf_q", {7'h0, ovf_q}, 8'h01);

    // Exhaustive sweep against an arithmetic reference model.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      logic       ci;
      a  = i[3:0];
      b  = i[7:4];
      ci = i[8];
      full  = {1'b0, a} + {1'b0, b} + {4'h0, ci};
      m_ovf = (a[3] == b[3]) && (full[3] != a[3]);
      apply(a, b, ci, full[3:0], full[4], m_ovf, "sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rca

`default_nettype wire

// File: doc/rca.md
RCA -- requirements
Module: rca

Interface
- REQ-001: No parameters; operand width is fixed at 4 bits.
- REQ-002: clk  input  1  single clock for the registered result stage.
- REQ-003: rst  input  1  reset, asynchronous and active-high.
- REQ-004: a0..a3  input  1 each  operand A bits, a0 = LSB.
- REQ-005: b0..b3  input  1 each  operand B bits, b0 = LSB.
- REQ-006: cin  input  1  carry into bit 0.
- REQ-007: s0..s3  output  1 each  combinational sum bits, s0 = LSB.
- REQ-008: c3  output  1  combinational carry out of bit 3.
- REQ-009: sum_q  output  4  registered copy of {s3,s2,s1,s0}.
- REQ-010: cout_q  output  1  registered copy of c3.
- REQ-011: ovf_q  output  1  registered two's-complement overflow flag.

Function
- REQ-012: {c3,s3,s2,s1,s0} SHALL equal A + B + cin, where A = {a3,a2,a1,a0} and B = {b3,b2,b1,b0}, both unsigned. The full 5-bit result is never truncated.
- REQ-013: The adder SHALL be a ripple chain of four full-adder stages.
  - Stage i: s_i = a_i ^ b_i ^ c_(i-1).
  - Stage i: c_i = a_i&b_i | a_i&c_(i-1) | b_i&c_(i-1).
  - c_(-1) = cin.
- REQ-014: s0..s3 and c3 SHALL be purely combinational.
  - Zero-cycle latency.
  - Independent of clk and rst.
  - Valid after ripple settling.
- REQ-015: The signed overflow value SHALL be c2 ^ c3, where c2 is the carry into bit 3.
- REQ-016: On every rising clk edge with rst low, the result registers SHALL load:
  - sum_q = {s3,s2,s1,s0}
  - cout_q = c3
  - ovf_q = c2 ^ c3
- REQ-017: The registered outputs SHALL have exactly one-cycle latency from input change to register output.
- REQ-018: Wrap-around: 15+15+1 SHALL give sum 1111 with c3 = 1, and 15+0+1 SHALL give sum 0000 with c3 = 1.
- REQ-019: Inputs changing between clock edges SHALL have no effect on the registers until the next rising edge. There is no enable or handshake.

Reset
- REQ-020: While rst is high, sum_q SHALL be 0000, cout_q SHALL be 0 and ovf_q SHALL be 0, asynchronously and without waiting for clk.
- REQ-021: Reset SHALL NOT affect the combinational outputs s0..s3 and c3.
- REQ-022: When rst is asserted mid-operation, the registers SHALL clear immediately. The first rising edge after rst deasserts SHALL capture the current inputs.

Structure
- REQ-023: The full-adder cell SHALL be a sub-module named full_adder, instantiated four times, with ports a, b, cin, s, cout.
- REQ-024: The shared package SHALL hold constant RCA_WIDTH = 4 and the reset value of the result registers (all zeros). No typedefs are required.
- REQ-025: The top level SHALL contain only the ripple interconnect, the overflow XOR and the result register process.

Verification
- REQ-026: A=1, B=12, cin=0 -> s=1101, c3=0; after one edge sum_q=1101, cout_q=0, ovf_q=0.
- REQ-027: A=5, B=10, cin=1 -> s=0000, c3=1; after one edge sum_q=0000, cout_q=1, ovf_q=0.
- REQ-028: A=6, B=5, cin=0 -> s=1011, c3=0; after one edge sum_q=1011, cout_q=0, ovf_q=1.
- REQ-029: A=15, B=15, cin=1 -> s=1111, c3=1, ovf_q=0. A=8, B=8, cin=0 -> s=0000, c3=1, ovf_q=1.
- REQ-030: Reset behaviour:
  - Load sum_q=1011.
  - Raise rst between edges: registers read 0 at once, and s still reads 1011.
  - Drop rst: the next edge reloads 1011.
- REQ-031: Exhaustive check: all 512 combinations of A, B and cin -> combinational outputs equal A+B+cin, and each registered output matches one cycle later.
